fetch_stage: RTL

// - IF stage plus IF/ID pipeline register. Generates the PC and fetches from a variable-latency instruction memory.
// - Presents {pc, pc4, instr, valid} to ID.
// - Obeys stall_IF, stall_ID and flush_ID from hazard_unit_forwarding. Redirects on a taken branch or jump resolved in EX.

---
 rtl/fetch_stage_pkg.sv | 32 +++
 rtl/fetch_stage_if.sv | 13 +
 rtl/if_id_reg.sv | 29 ++
 rtl/fetch_stage.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/fetch_stage_pkg.sv
// Shared types and constants for the fetch stage: FSM states, the canonical NOP
// and the IF/ID payload struct. Struct fields are PKG_XLEN wide.
package fetch_stage_pkg;

  localparam int unsigned PKG_XLEN = 32;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_REQ,
    S_WAIT,
    S_KILL
  } fetch_state_e;

  typedef struct packed {
    logic [PKG_XLEN-1:0] pc;
    logic [PKG_XLEN-1:0] pc4;
    logic [31:0]         instr;
    logic                valid;
  } if_id_t;

  // A bubble keeps the PC fields so ID_pc/ID_pc4 stay meaningful for debug.
  function automatic if_id_t bubble(input if_id_t cur);
    if_id_t b;
    b       = cur;
    b.instr = NOP_INSTR;
    b.valid = 1'b0;
    return b;
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response bus. One request may be outstanding;
// the memory accepts a request in the cycle req is high.
interface fetch_stage_if #(
  parameter int unsigned XLEN = 32
);
  logic            req;
  logic [XLEN-1:0] addr;
  logic            valid;
  logic [31:0]     rdata;

  modport master (output req, addr, input valid, rdata);
  modport slave  (input req, addr, output valid, rdata);
endinterface

// File: rtl/if_id_reg.sv
// IF/ID pipeline register. Priority: flush > stall > load; an unloaded,
// unstalled cycle inserts a bubble.
module if_id_reg
  import fetch_stage_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   stall,
  input  logic   flush,
  input  logic   load,
  input  if_id_t d,
  output if_id_t q
);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q.pc    <= '0;
      q.pc4   <= PKG_XLEN'(4);
      q.instr <= NOP_INSTR;
      q.valid <= 1'b0;
    end else if (flush) begin
      q <= bubble(q);
    end else if (!stall) begin
      q <= load ? d : bubble(q);
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// IF stage: PC, fetch FSM, one-entry hold buffer and optional perf counters
// (FETCH_PERF_EN). XLEN must equal fetch_stage_pkg::PKG_XLEN.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter int unsigned     XLEN     = PKG_XLEN,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall_IF,
  input  logic             stall_ID,
  input  logic             flush_ID,
  input  logic             EX_br_sel,
  input  logic [XLEN-1:0]  EX_br_target,
  fetch_stage_if.master    imem,
  output logic [XLEN-1:0]  ID_pc,
  output logic [XLEN-1:0]  ID_pc4,
  output logic [31:0]      ID_instr,
  output logic             ID_valid,
  output logic [31:0]      perf_stall_cnt,
  output logic [31:0]      perf_flush_cnt
);

  fetch_state_e    state, state_nxt;
  logic [XLEN-1:0] pc, req_pc;
  logic            req, rsp_take;
  logic            hold_valid;
  logic [XLEN-1:0] hold_pc;
  logic [31:0]     hold_instr;
  logic            deliver, capture, drain;
  if_id_t          if_id_d, if_id_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_REQ;
    else     state <= state_nxt;
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    req       = 1'b0;
    rsp_take  = 1'b0;
    unique case (state)
      S_REQ: begin
        req = !rst && !EX_br_sel && !stall_IF && !hold_valid;
        if (req) state_nxt = S_WAIT;
      end
      S_WAIT: begin
        // A redirect with the response already here drops it; nothing stays outstanding.
        if (EX_br_sel) begin
          state_nxt = imem.valid ? S_REQ : S_KILL;
        end else if (imem.valid) begin
          rsp_take = 1'b1;
          req      = !stall_IF && !stall_ID;
          if (!req) state_nxt = S_REQ;
        end
      end
      S_KILL: begin
        if (imem.valid) state_nxt = S_REQ;
      end
      default: state_nxt = S_REQ;
    endcase
  end

  assign imem.req  = req;
  assign imem.addr = pc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc     <= RESET_PC;
      req_pc <= RESET_PC;
    end else if (EX_br_sel) begin
      pc <= EX_br_target;
    end else if (req) begin
      pc     <= pc + XLEN'(4);
      req_pc <= pc;
    end
  end

  // flush_ID only affects IF/ID; the fetch side hands words over as if unflushed.
  assign deliver = rsp_take && !stall_ID;
  assign capture = rsp_take && stall_ID;
  assign drain   = hold_valid && !stall_ID && !EX_br_sel;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)            hold_valid <= 1'b0;
    else if (EX_br_sel) hold_valid <= 1'b0;
    else if (capture)   hold_valid <= 1'b1;
    else if (drain)     hold_valid <= 1'b0;
  end

  // NOTE: hold data needs no reset; hold_valid alone qualifies it.
  always_ff @(posedge clk) begin
    if (capture) begin
      hold_pc    <= req_pc;
      hold_instr <= imem.rdata;
    end
  end

  always_comb begin
    if_id_d       = '0;
    if_id_d.pc    = drain ? hold_pc : req_pc;
    if_id_d.pc4   = if_id_d.pc + PKG_XLEN'(4);
    if_id_d.instr = drain ? hold_instr : imem.rdata;
    if_id_d.valid = 1'b1;
  end

  if_id_reg u_if_id_reg (
    .clk   (clk),
    .rst   (rst),
    .stall (stall_ID),
    .flush (flush_ID),
    .load  (deliver || drain),
    .d     (if_id_d),
    .q     (if_id_q)
  );

  assign ID_pc    = if_id_q.pc;
  assign ID_pc4   = if_id_q.pc4;
  assign ID_instr = if_id_q.instr;
  assign ID_valid = if_id_q.valid;

`ifdef FETCH_PERF_EN
  logic [31:0] stall_cnt_q, flush_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (stall_IF && stall_cnt_q != '1) stall_cnt_q <= stall_cnt_q + 32'd1;
      if (flush_ID && flush_cnt_q != '1) flush_cnt_q <= flush_cnt_q + 32'd1;
    end
  end

  assign perf_stall_cnt = stall_cnt_q;
  assign perf_flush_cnt = flush_cnt_q;
`else
  assign perf_stall_cnt = '0;
  assign perf_flush_cnt = '0;
`endif

endmodule
